// File: rtl/btb_predictor_pkg.sv
// Shared types and constants for the branch target buffer.
package btb_predictor_pkg;

    // Two-bit saturating counter encodings.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    // Counter value given to a freshly allocated entry.
    localparam logic [1:0] CNT_ALLOC = 2'b10;

    // Widest tag over the supported table sizes (4 entries -> 28-bit tag).
    localparam int unsigned TAG_MAX_W = 28;
    localparam int unsigned TGT_W     = 30;

    // One table entry as seen by a lookup; narrower tags are zero-extended.
    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [TGT_W-1:0]     target;
        logic [1:0]           cnt;
    } btb_entry_t;

    // Taken prediction from a counter value.
    function automatic logic predict_taken(input logic [1:0] cnt);
        return (cnt == WT) || (cnt == ST);
    endfunction

endpackage

// File: rtl/btb_predictor_sat_counter2.sv
// Combinational 2-bit saturating increment/decrement.
module sat_counter2
    import btb_predictor_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       inc,
    output logic [1:0] cnt_next_c
);

    // Step towards strongly taken on inc, strongly not-taken otherwise.
    always_comb begin
        cnt_next_c = cnt;
        if (inc) begin
            if (cnt != ST) cnt_next_c = 2'(cnt + 2'd1);
        end else begin
            if (cnt != SNT) cnt_next_c = 2'(cnt - 2'd1);
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit counters and a misprediction counter.
module btb_predictor
    import btb_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES  = 16,
    parameter logic [1:0]  CNT_INIT = 2'b01
)(
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] PF_PC,
    output logic        branch,
    output logic [31:0] target_addr,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict,
    output logic [31:0] mispredict_cnt
);

    localparam int unsigned IW = $clog2(ENTRIES);
    localparam int unsigned TW = 30 - IW;

    logic              valid_q [ENTRIES];
    logic [1:0]        cnt_q   [ENTRIES];
    logic [TW-1:0]     tag_q   [ENTRIES];
    logic [TGT_W-1:0]  tgt_q   [ENTRIES];
    logic [31:0]       mis_q;

    logic [IW-1:0]     pf_idx;
    logic [TW-1:0]     pf_tag;
    btb_entry_t        pf_ent;
    logic              pf_hit;

    logic [IW-1:0]     upd_idx;
    logic [TW-1:0]     upd_tag;
    logic              upd_hit;
    logic [1:0]        upd_cnt;
    logic [1:0]        upd_cnt_next_c;

    // Low address bits carry no information for word-aligned PCs and targets.
    logic              unused_lsbs;
    assign unused_lsbs = ^{upd_pc[1:0], upd_target[1:0]};

    assign pf_idx  = PF_PC[IW+1:2];
    assign pf_tag  = PF_PC[31:IW+2];
    assign upd_idx = upd_pc[IW+1:2];
    assign upd_tag = upd_pc[31:IW+2];

    // Read the entry addressed by the prefetch PC (pre-update contents).
    always_comb begin
        pf_ent.valid  = valid_q[pf_idx];
        pf_ent.tag    = TAG_MAX_W'(tag_q[pf_idx]);
        pf_ent.target = tgt_q[pf_idx];
        pf_ent.cnt    = cnt_q[pf_idx];
    end

    assign pf_hit      = pf_ent.valid && (pf_ent.tag == TAG_MAX_W'(pf_tag));
    assign branch      = pf_hit && predict_taken(pf_ent.cnt);
    assign target_addr = pf_hit ? {pf_ent.target, 2'b00} : PF_PC + 32'd4;

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_cnt = cnt_q[upd_idx];

    sat_counter2 u_sat_counter2 (
        .cnt        (upd_cnt),
        .inc        (upd_taken),
        .cnt_next_c (upd_cnt_next_c)
    );

    // Valid bits and counters: cleared on reset, trained by resolved branches.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= CNT_INIT;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                cnt_q[upd_idx] <= upd_cnt_next_c;
            end else if (upd_taken) begin
                valid_q[upd_idx] <= 1'b1;
                cnt_q[upd_idx]   <= CNT_ALLOC;
            end
        end
    end

    // Tag and target storage: written on any taken update, never reset.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            tag_q[upd_idx] <= upd_tag;
            tgt_q[upd_idx] <= upd_target[31:2];
        end
    end

    // Saturating misprediction count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mis_q <= 32'd0;
        end else if (upd_valid && upd_mispredict && (mis_q != 32'hFFFF_FFFF)) begin
            mis_q <= mis_q + 32'd1;
        end
    end

    assign mispredict_cnt = mis_q;

endmodule

// File: doc/btb_predictor.md
BTB_PREDICTOR -- requirements
Module: btb_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16: number of direct-mapped table entries, a power of two from 4 to 64.
REQ-002 SHALL have parameter CNT_INIT, default 2'b01: counter value written into a valid entry by reset (weakly not-taken).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port PF_PC, input, 32 bits: pre-fetch PC being looked up.
REQ-006 SHALL have port branch, output, 1 bit: predict taken for PF_PC; goes to npc.
REQ-007 SHALL have port target_addr, output, 32 bits: predicted target for PF_PC; goes to npc.
REQ-008 SHALL have port upd_valid, input, 1 bit: a resolved control-transfer instruction is presented this cycle.
REQ-009 SHALL have port upd_pc, input, 32 bits: PC of the resolved instruction.
REQ-010 SHALL have port upd_taken, input, 1 bit: actual outcome of the resolved instruction.
REQ-011 SHALL have port upd_target, input, 32 bits: actual target of the resolved instruction.
REQ-012 SHALL have port upd_mispredict, input, 1 bit: npc flagged branch_error for the resolved instruction.
REQ-013 SHALL have port mispredict_cnt, output, 32 bits: saturating count of mispredictions.

Function
REQ-014 SHALL use index idx = PC[IW+1:2] with IW = log2(ENTRIES), and tag = PC[31:IW+2].
REQ-015 SHALL store per entry: valid, tag, 30-bit target[31:2], 2-bit counter.
REQ-016 SHALL form the lookup combinationally from PF_PC: hit = valid & tag match.
REQ-017 SHALL drive branch = hit & counter[1], with zero-cycle latency from PF_PC.
REQ-018 SHALL drive target_addr = {target, 2'b00} on a hit, and PF_PC + 4 otherwise.
REQ-019 SHALL update the entry at idx(upd_pc) at the clock edge when upd_valid=1.
REQ-020 On an update hit with upd_taken=1: counter SHALL increment, saturating at 2'b11, and target SHALL be overwritten with upd_target.
REQ-021 On an update hit with upd_taken=0: counter SHALL decrement, saturating at 2'b00, and target SHALL be unchanged.
REQ-022 On an update miss with upd_taken=1: the entry SHALL be allocated or replaced with valid=1, the new tag, upd_target, and counter=2'b10.
REQ-023 On an update miss with upd_taken=0: there SHALL be no state change.
REQ-024 A lookup and an update to the same index in the same cycle SHALL return the pre-update contents; the new contents SHALL be visible from the next cycle.
REQ-025 upd_target[1:0] SHALL be ignored.
REQ-026 upd_* inputs SHALL be ignored while upd_valid=0.
REQ-027 mispredict_cnt SHALL increment by 1 when upd_valid & upd_mispredict, and SHALL hold at 32'hFFFF_FFFF.

Reset
REQ-028 resetn=0 SHALL immediately clear every valid bit, set every counter to CNT_INIT, and clear mispredict_cnt.
REQ-029 Tag and target storage SHALL need no reset.
REQ-030 During reset and on the first cycle after it, branch SHALL be 0 and target_addr SHALL be PF_PC + 4.
REQ-031 An update presented in the cycle reset deasserts SHALL be applied normally.
REQ-032 Assertion of reset at any time SHALL discard all table state.

Structure
REQ-033 The shared package SHALL hold: counter encodings (SNT=00, WNT=01, WT=10, ST=11), the counter-allocate value 2'b10, and a btb_entry typedef.
REQ-034 The block SHALL contain one sub-module, sat_counter2: combinational 2-bit saturating increment/decrement.
REQ-035 Tables SHALL be flop arrays; no SRAM macro.

Verification
REQ-036 Reset then PF_PC=32'hBFC0_0000 -> branch=0, target_addr=32'hBFC0_0004.
REQ-037 Update pc=32'h8000_0010, taken=1, target=32'h8000_0100 -> next cycle, PF_PC=32'h8000_0010 gives branch=1, target_addr=32'h8000_0100.
REQ-038 Following REQ-037, two not-taken updates to the same pc -> counter 10->01->00, branch=0; one taken update -> 01, branch still 0.
REQ-039 Alias case: update pc=32'h8000_0050, taken=1 (same index as 32'h8000_0010 at ENTRIES=16) -> lookup of 32'h8000_0010 misses, branch=0, target_addr=32'h8000_0014.
REQ-040 Lookup and update to the same index in one cycle -> old prediction that cycle, new prediction the next cycle.
REQ-041 Three updates with upd_mispredict=1, then resetn pulsed low mid-cycle -> mispredict_cnt reads 3, then 0 asynchronously; all lookups miss.
